risc16_core: RTL and testbench
==============================

# risc16_core

Single-cycle RiSC-16 processor core: eight 16-bit registers (r0 hardwired to zero), an 8-instruction ISA, and separate instruction and data memory ports. Every instruction completes in one clock. The core sits beneath the system top level. That top level supplies instructions from a word-addressed ROM indexed by `o_pc` and attaches a data RAM with asynchronous read and synchronous write.

## Interface
- Parameters: none (word width fixed at 16, register count fixed at 8).
- `i_clk` in 1: the single clock; all state updates on its rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_inst` in 16: instruction at address `o_pc`, valid combinationally in the same cycle.
- `o_pc` out 16: current program counter, word address, registered.
- `i_mem_rd_data` in 16: data-memory read word for `o_mem_addr`, combinational in the same cycle.
- `o_mem_addr` out 16: data address `rB + sext(imm7)`, combinational.
- `o_mem_wr_data` out 16: store data, equal to the value of register rA, combinational.
- `o_mem_wr_en` out 1: high only while the current instruction is SW, combinational.

## Operation
- Fields: op=`i_inst[15:13]`, rA=[12:10], rB=[9:7], rC=[2:0], imm7=[6:0] sign-extended to 16, imm10=[9:0].
- Register file: 8×16, two combinational read ports (rA/rB or rB/rC as needed), one write port written on the clock edge. Writes to r0 are discarded and r0 always reads 0.
- All arithmetic is 16-bit modulo 2^16, with no flags or traps.

Opcode behaviour (next PC = pc+1 unless noted):
- 000 ADD: rA ← rB + rC.
- 001 ADDI: rA ← rB + sext(imm7).
- 010 NAND: rA ← ~(rB & rC).
- 011 LUI: rA ← {imm10, 6'b0}.
- 100 SW: `o_mem_wr_en`=1, addr=rB+sext(imm7), data=rA. No register write.
- 101 LW: rA ← `i_mem_rd_data`, with addr=rB+sext(imm7).
- 110 BEQ: if rA==rB, next PC = pc+1+sext(imm7); otherwise pc+1. No register write.
- 111 JALR: rA ← pc+1, then next PC = rB. The old value of rB is used when rA==rB. imm7 is ignored.

Other rules:
- For non-memory instructions, `o_mem_addr` and `o_mem_wr_data` still show rB+sext(imm7) and rA, but `o_mem_wr_en`=0.
- PC wraps modulo 2^16.
- Any out-of-range address masking (e.g. addr ≥ 1024) is done at the system level, not in the core.

## Timing
- Single cycle, in this order:
  1. `o_pc` selects `i_inst`.
  2. Decode, register read, ALU and memory address settle combinationally.
  3. At the rising `i_clk`, PC, the destination register, and the external RAM write (when `o_mem_wr_en`) all commit together.
- Latency: a result written in cycle N is readable by the instruction in cycle N+1, with no hazards.
- Reset:
  - `i_rst_n`=0 immediately forces `o_pc`=0 and clears all registers to 0, independent of the clock.
  - While reset is held, no register or PC update occurs. `o_mem_wr_en` follows `i_inst` decode, but the core suppresses it to 0 during reset.
  - Reset asserted mid-program discards the in-flight instruction. The first instruction after release executes from address 0 on the first rising edge with `i_rst_n`=1.
- Simultaneous events: a SW and a PC update occur on the same edge. An LW whose rA equals its rB uses the pre-edge rB for the address.

## Test plan
- Reset: hold `i_rst_n`=0 with clock running → `o_pc`=0, all registers 0, `o_mem_wr_en`=0. Release → `o_pc` goes 1, 2, 3 on successive edges for NOP (`0x0000`).
- ALU: `ADDI r1,r0,5`; `ADDI r2,r0,-3`; `ADD r3,r1,r2` → r3=2; `NAND r4,r1,r1` → 0xFFFA; `LUI r5,0x3FF` → 0xFFC0; `ADDI r0,r0,7` → r0 still reads 0.
- Memory: r1=10, r2=0x1234; `SW r2,r1,3` → on that cycle `o_mem_wr_en`=1, `o_mem_addr`=13, `o_mem_wr_data`=0x1234. Next, `LW r3,r1,3` with RAM returning 0x1234 → r3=0x1234, `o_mem_wr_en`=0.
- Branch: at pc=4, r1=r2=7, `BEQ r1,r2,-5` → next `o_pc`=0. With r1≠r2 → next `o_pc`=5. Also `BEQ` imm=+63 from pc=0xFFF0 → next `o_pc`=0x0030 (wrap).
- Jump: at pc=8, r2=0x20, `JALR r7,r2` → r7=9, next `o_pc`=0x20. `JALR r2,r2` → r2=pc+1 and jump to the old r2.
- Async reset mid-run: assert `i_rst_n`=0 between edges while pc=0x15 → `o_pc`=0 before the next edge, and registers read 0.

Source files
------------

// File: rtl/risc16_core.sv
// Single-cycle RiSC-16 core: eight 16-bit registers (r0 reads zero),
// eight opcodes, and separate instruction and data memory ports.
// Every instruction decodes, executes and commits within one clock.
module risc16_core (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_inst,
  output logic [15:0] o_pc,
  input  logic [15:0] i_mem_rd_data,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wr_data,
  output logic        o_mem_wr_en
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_t;

  logic [15:0] pc;
  logic [15:0] regs [8];

  opcode_t     op;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  rc;
  logic [15:0] imm7_sext;
  logic [15:0] imm10_hi;
  logic [15:0] val_a;
  logic [15:0] val_b;
  logic [15:0] val_c;
  logic [15:0] pc_plus1;
  logic [15:0] ea;
  logic [15:0] next_pc;
  logic [15:0] wb_data;
  logic        wb_en;

  // Field extraction and combinational register reads; r0 is forced to zero
  // here so the storage slot for r0 never matters.
  always_comb begin
    op        = opcode_t'(i_inst[15:13]);
    ra        = i_inst[12:10];
    rb        = i_inst[9:7];
    rc        = i_inst[2:0];
    imm7_sext = {{9{i_inst[6]}}, i_inst[6:0]};
    imm10_hi  = {i_inst[9:0], 6'b000000};
    val_a     = (ra == 3'd0) ? 16'h0000 : regs[ra];
    val_b     = (rb == 3'd0) ? 16'h0000 : regs[rb];
    val_c     = (rc == 3'd0) ? 16'h0000 : regs[rc];
    pc_plus1  = pc + 16'd1;
    ea        = val_b + imm7_sext;
  end

  // Execute: choose the write-back value and the next PC for each opcode.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = 16'h0000;
    next_pc = pc_plus1;
    case (op)
      OP_ADD: begin
        wb_en   = 1'b1;
        wb_data = val_b + val_c;
      end
      OP_ADDI: begin
        wb_en   = 1'b1;
        wb_data = ea;
      end
      OP_NAND: begin
        wb_en   = 1'b1;
        wb_data = ~(val_b & val_c);
      end
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm10_hi;
      end
      OP_SW: begin
        wb_en = 1'b0;
      end
      OP_LW: begin
        wb_en   = 1'b1;
        wb_data = i_mem_rd_data;
      end
      OP_BEQ: begin
        if (val_a == val_b) begin
          next_pc = pc_plus1 + imm7_sext;
        end
      end
      OP_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc_plus1;
        next_pc = val_b;
      end
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  // Data memory port; the write strobe is gated off while reset is held so
  // the RAM cannot be written by whatever instruction the ROM shows at PC 0.
  always_comb begin
    o_pc          = pc;
    o_mem_addr    = ea;
    o_mem_wr_data = val_a;
    o_mem_wr_en   = (op == OP_SW) && i_rst_n;
  end

  // Architectural state commit: PC and destination register update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc <= 16'h0000;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      pc <= next_pc;
      if (wb_en && (ra != 3'd0)) begin
        regs[ra] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_risc16_core.sv
// Directed testbench for risc16_core with a queue-based scoreboard: the
// stimulus pushes the expected port values for each issued instruction and
// an independent monitor pops and compares them at each sample point.
module tb_risc16_core;

  logic        i_clk;
  logic        i_rst_n;
  logic [15:0] i_inst;
  logic [15:0] o_pc;
  logic [15:0] i_mem_rd_data;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wr_data;
  logic        o_mem_wr_en;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } expect_t;

  expect_t exp_q[$];
  int      total_checks;
  int      bad_checks;
  event    sample_ev;

  risc16_core dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_inst        (i_inst),
    .o_pc          (o_pc),
    .i_mem_rd_data (i_mem_rd_data),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .o_mem_wr_en   (o_mem_wr_en)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Sample point: mid-way through the low phase, well away from the rising edge.
  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      -> sample_ev;
    end
  end

  // Absolute bound on the run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] enc_rrr(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, 4'b0000, c};
  endfunction

  function automatic logic [15:0] enc_rri(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [6:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [15:0] enc_ri(input logic [2:0] op, input logic [2:0] a,
                                         input logic [9:0] imm);
    return {op, a, imm};
  endfunction

  task automatic check_output(input string name, input string field,
                              input logic [15:0] actual, input logic [15:0] required);
    total_checks++;
    if (actual !== required) begin
      bad_checks++;
      $display("[TB] FAIL %s.%s: got 0x%04h, expected 0x%04h", name, field, actual, required);
    end
  endtask

  // Monitor: whenever an expectation is pending at a sample point, compare it.
  initial begin
    expect_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e.name, "pc", o_pc, e.pc);
        check_output(e.name, "wr_en", {15'h0000, o_mem_wr_en}, {15'h0000, e.we});
        check_output(e.name, "addr", o_mem_addr, e.addr);
        check_output(e.name, "wr_data", o_mem_wr_data, e.wdata);
      end
    end
  end

  task automatic push_expect(input string name, input logic [15:0] pc, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata);
    expect_t e;
    e.name  = name;
    e.pc    = pc;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input string name, input logic [15:0] inst,
                                input logic [15:0] rd, input logic [15:0] pc,
                                input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata);
    @(negedge i_clk);
    i_inst        = inst;
    i_mem_rd_data = rd;
    push_expect(name, pc, we, addr, wdata);
  endtask

  task automatic release_reset(input string name);
    @(negedge i_clk);
    i_rst_n       = 1'b1;
    i_inst        = 16'h0000;
    i_mem_rd_data = 16'h0000;
    push_expect(name, 16'h0000, 1'b0, 16'h0000, 16'h0000);
  endtask

  localparam logic [2:0] ADD = 3'b000, ADDI = 3'b001, NAND = 3'b010, LUI = 3'b011;
  localparam logic [2:0] SW = 3'b100, LW = 3'b101, BEQ = 3'b110, JALR = 3'b111;

  initial begin
    total_checks  = 0;
    bad_checks    = 0;
    i_rst_n       = 1'b0;
    i_inst        = enc_rri(SW, 3'd1, 3'd2, 7'd5);
    i_mem_rd_data = 16'h0000;

    // Reset held with a store visible: no PC movement, write strobe suppressed.
    apply_stimulus("rst_hold0", enc_rri(SW, 3'd1, 3'd2, 7'd5), 16'h0, 16'h0000, 1'b0, 16'h0005, 16'h0000);
    apply_stimulus("rst_hold1", enc_rri(SW, 3'd1, 3'd2, 7'd5), 16'h0, 16'h0000, 1'b0, 16'h0005, 16'h0000);
    release_reset("nop_pc0");
    apply_stimulus("nop_pc1", 16'h0000, 16'h0, 16'h0001, 1'b0, 16'h0000, 16'h0000);
    apply_stimulus("nop_pc2", 16'h0000, 16'h0, 16'h0002, 1'b0, 16'h0000, 16'h0000);
    apply_stimulus("nop_pc3", 16'h0000, 16'h0, 16'h0003, 1'b0, 16'h0000, 16'h0000);

    // ALU group, then read registers back through stores.
    apply_stimulus("addi_r1", enc_rri(ADDI, 3'd1, 3'd0, 7'd5),    16'h0, 16'h0004, 1'b0, 16'h0005, 16'h0000);
    apply_stimulus("addi_r2", enc_rri(ADDI, 3'd2, 3'd0, 7'h7D),   16'h0, 16'h0005, 1'b0, 16'hFFFD, 16'h0000);
    apply_stimulus("add_r3",  enc_rrr(ADD, 3'd3, 3'd1, 3'd2),     16'h0, 16'h0006, 1'b0, 16'h0007, 16'h0000);
    apply_stimulus("nand_r4", enc_rrr(NAND, 3'd4, 3'd1, 3'd1),    16'h0, 16'h0007, 1'b0, 16'h0006, 16'h0000);
    apply_stimulus("lui_r5",  enc_ri(LUI, 3'd5, 10'h3FF),         16'h0, 16'h0008, 1'b0, 16'hFFFF, 16'h0000);
    apply_stimulus("addi_r0", enc_rri(ADDI, 3'd0, 3'd0, 7'd7),    16'h0, 16'h0009, 1'b0, 16'h0007, 16'h0000);
    apply_stimulus("sw_r3",   enc_rri(SW, 3'd3, 3'd0, 7'd0),      16'h0, 16'h000A, 1'b1, 16'h0000, 16'h0002);
    apply_stimulus("sw_r4",   enc_rri(SW, 3'd4, 3'd0, 7'd1),      16'h0, 16'h000B, 1'b1, 16'h0001, 16'hFFFA);
    apply_stimulus("sw_r5",   enc_rri(SW, 3'd5, 3'd0, 7'd2),      16'h0, 16'h000C, 1'b1, 16'h0002, 16'hFFC0);
    apply_stimulus("sw_r0",   enc_rri(SW, 3'd0, 3'd0, 7'd3),      16'h0, 16'h000D, 1'b1, 16'h0003, 16'h0000);
    apply_stimulus("sw_r2",   enc_rri(SW, 3'd2, 3'd0, 7'd0),      16'h0, 16'h000E, 1'b1, 16'h0000, 16'hFFFD);

    // Memory group: r1=10, r2=0x1234, store then load at address 13.
    apply_stimulus("addi_r1_10", enc_rri(ADDI, 3'd1, 3'd0, 7'd10),  16'h0, 16'h000F, 1'b0, 16'h000A, 16'h0005);
    apply_stimulus("lui_r2",     enc_ri(LUI, 3'd2, 10'h048),        16'h0, 16'h0010, 1'b0, 16'hFFC8, 16'hFFFD);
    apply_stimulus("addi_r2",    enc_rri(ADDI, 3'd2, 3'd2, 7'h34),  16'h0, 16'h0011, 1'b0, 16'h1234, 16'h1200);
    apply_stimulus("sw_mem",     enc_rri(SW, 3'd2, 3'd1, 7'd3),     16'h0, 16'h0012, 1'b1, 16'h000D, 16'h1234);
    apply_stimulus("lw_mem",     enc_rri(LW, 3'd3, 3'd1, 7'd3), 16'h1234, 16'h0013, 1'b0, 16'h000D, 16'h0002);
    apply_stimulus("sw_lw_r3",   enc_rri(SW, 3'd3, 3'd0, 7'd0),     16'h0, 16'h0014, 1'b1, 16'h0000, 16'h1234);
    apply_stimulus("lw_same",    enc_rri(LW, 3'd1, 3'd1, 7'd3), 16'h0055, 16'h0015, 1'b0, 16'h000D, 16'h000A);
    apply_stimulus("sw_lw_r1",   enc_rri(SW, 3'd1, 3'd0, 7'd0),     16'h0, 16'h0016, 1'b1, 16'h0000, 16'h0055);

    // Branch group: taken backwards, not taken, and forward across the wrap.
    apply_stimulus("addi_r1_7", enc_rri(ADDI, 3'd1, 3'd0, 7'd7),  16'h0, 16'h0017, 1'b0, 16'h0007, 16'h0055);
    apply_stimulus("addi_r2_7", enc_rri(ADDI, 3'd2, 3'd0, 7'd7),  16'h0, 16'h0018, 1'b0, 16'h0007, 16'h1234);
    apply_stimulus("beq_taken", enc_rri(BEQ, 3'd1, 3'd2, 7'h7B),  16'h0, 16'h0019, 1'b0, 16'h0002, 16'h0007);
    apply_stimulus("beq_not",   enc_rri(BEQ, 3'd1, 3'd3, 7'd2),   16'h0, 16'h0015, 1'b0, 16'h1236, 16'h0007);
    apply_stimulus("lui_r6",    enc_ri(LUI, 3'd6, 10'h3FF),       16'h0, 16'h0016, 1'b0, 16'hFFFF, 16'h0000);
    apply_stimulus("addi_r6",   enc_rri(ADDI, 3'd6, 3'd6, 7'd48), 16'h0, 16'h0017, 1'b0, 16'hFFF0, 16'hFFC0);
    apply_stimulus("jalr_r7",   enc_rri(JALR, 3'd7, 3'd6, 7'd0),  16'h0, 16'h0018, 1'b0, 16'hFFF0, 16'h0000);
    apply_stimulus("beq_wrap",  enc_rri(BEQ, 3'd0, 3'd0, 7'd63),  16'h0, 16'hFFF0, 1'b0, 16'h003F, 16'h0000);
    apply_stimulus("sw_r7",     enc_rri(SW, 3'd7, 3'd0, 7'd0),    16'h0, 16'h0030, 1'b1, 16'h0000, 16'h0019);

    // Jump with rA == rB: link written, target taken from the old rB.
    apply_stimulus("addi_r2_15", enc_rri(ADDI, 3'd2, 3'd0, 7'h15), 16'h0, 16'h0031, 1'b0, 16'h0015, 16'h0007);
    apply_stimulus("jalr_same",  enc_rri(JALR, 3'd2, 3'd2, 7'd0),  16'h0, 16'h0032, 1'b0, 16'h0015, 16'h0015);
    apply_stimulus("sw_link",    enc_rri(SW, 3'd2, 3'd0, 7'd1),    16'h0, 16'h0015, 1'b1, 16'h0001, 16'h0033);

    // Asynchronous reset between edges while pc=0x15: must act before the next edge.
    #3;
    i_rst_n = 1'b0;
    push_expect("async_rst", 16'h0000, 1'b0, 16'h0001, 16'h0000);
    #1;
    -> sample_ev;
    release_reset("rel_pc0");
    apply_stimulus("sw_r2_clr", enc_rri(SW, 3'd2, 3'd0, 7'd1), 16'h0, 16'h0001, 1'b1, 16'h0001, 16'h0000);
    apply_stimulus("sw_r7_clr", enc_rri(SW, 3'd7, 3'd0, 7'd0), 16'h0, 16'h0002, 1'b1, 16'h0000, 16'h0000);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge i_clk);
      #3;
    end
    check_output("drain", "pending", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
